// File: rtl/parallel_window_feeder.sv
// Raster pixel stream to 4-row x 2-column tiles for Parallel_filter (three line buffers + column latch).
// Latency: tile registered one cycle after its odd-column pixel; no backpressure, every accepted pixel is consumed.
module parallel_window_feeder #(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int ROW_STEP = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [7:0]                 in_pixel,
    output logic [7:0]                 I_00,
    output logic [7:0]                 I_01,
    output logic [7:0]                 I_02,
    output logic [7:0]                 I_03,
    output logic [7:0]                 I_10,
    output logic [7:0]                 I_11,
    output logic [7:0]                 I_12,
    output logic [7:0]                 I_13,
    output logic                       out_valid,
    output logic [$clog2(IMG_W)-2:0]   out_col,
    output logic [7:0]                 out_band,
    output logic                       frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int PW = (ROW_STEP > 1) ? $clog2(ROW_STEP) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_FIRST_TILE = YW'(3);
    localparam logic [PW-1:0] P_LAST = PW'(ROW_STEP - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [1:0]      ym3;
    logic [PW-1:0]   ph;
    logic [7:0]      band;
    logic [3:0][7:0] lat;

    logic [7:0] lb0 [0:IMG_W-1];
    logic [7:0] lb1 [0:IMG_W-1];
    logic [7:0] lb2 [0:IMG_W-1];

    logic          acc;
    logic          emit;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [1:0]    cym3;
    logic [PW-1:0] cph;
    logic [7:0]    cband;
    logic [7:0]    rd0, rd1, rd2;
    logic [7:0]    r3, r2, r1;

    // A start-of-frame pixel is (0,0) whatever the counters say, so all per-pixel logic uses the c* view.
    always_comb begin
        acc   = in_valid && (in_sof || state == RUN);
        cx    = in_sof ? '0 : x;
        cy    = in_sof ? '0 : y;
        cym3  = in_sof ? 2'd0 : ym3;
        cph   = in_sof ? '0 : ph;
        cband = in_sof ? 8'd0 : band;
        rd0   = lb0[cx];
        rd1   = lb1[cx];
        rd2   = lb2[cx];
        r3    = rd0;
        r2    = rd1;
        r1    = rd2;
        case (cym3)
            2'd1:    begin r3 = rd1; r2 = rd2; r1 = rd0; end
            2'd2:    begin r3 = rd2; r2 = rd0; r1 = rd1; end
            default: begin r3 = rd0; r2 = rd1; r1 = rd2; end
        endcase
        emit = acc && cx[0] && (cy >= Y_FIRST_TILE) && (cph == '0);
    end

    // Reads above see the pre-write contents, so the buffer being overwritten still yields row y-3.
    always_ff @(posedge clk) begin
        if (!rst && acc) begin
            case (cym3)
                2'd1:    lb1[cx] <= in_pixel;
                2'd2:    lb2[cx] <= in_pixel;
                default: lb0[cx] <= in_pixel;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            ym3        <= 2'd0;
            ph         <= '0;
            band       <= 8'd0;
            lat        <= '0;
            I_00       <= 8'd0;
            I_01       <= 8'd0;
            I_02       <= 8'd0;
            I_03       <= 8'd0;
            I_10       <= 8'd0;
            I_11       <= 8'd0;
            I_12       <= 8'd0;
            I_13       <= 8'd0;
            out_valid  <= 1'b0;
            out_col    <= '0;
            out_band   <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= emit;
            frame_done <= 1'b0;
            if (acc) begin
                if (!cx[0]) begin
                    lat <= {in_pixel, r1, r2, r3};
                end
                if (emit) begin
                    I_00     <= lat[0];
                    I_01     <= lat[1];
                    I_02     <= lat[2];
                    I_03     <= lat[3];
                    I_10     <= r3;
                    I_11     <= r2;
                    I_12     <= r1;
                    I_13     <= in_pixel;
                    out_col  <= cx[XW-1:1];
                    out_band <= cband;
                end
                if (cx == X_LAST && cy == Y_LAST) begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                    x          <= '0;
                    y          <= '0;
                    ym3        <= 2'd0;
                    ph         <= '0;
                    band       <= 8'd0;
                end else begin
                    state <= RUN;
                    if (cx == X_LAST) begin
                        x   <= '0;
                        y   <= cy + 1'b1;
                        ym3 <= (cym3 == 2'd2) ? 2'd0 : cym3 + 2'd1;
                        // Band phase only starts counting once row 3 (the first full band) has been passed.
                        if (cy >= Y_FIRST_TILE) begin
                            ph   <= (cph == P_LAST) ? '0 : cph + 1'b1;
                            band <= (cph == P_LAST) ? cband + 8'd1 : cband;
                        end else begin
                            ph   <= '0;
                            band <= 8'd0;
                        end
                    end else begin
                        x    <= cx + 1'b1;
                        y    <= cy;
                        ym3  <= cym3;
                        ph   <= cph;
                        band <= cband;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_parallel_window_feeder.sv
// Bench: two feeders (ROW_STEP 4 and 1) on a shared 16x8 ramp stream, checked every cycle against an image-level model.
module tb_parallel_window_feeder;

    localparam int W = 16;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic [7:0] in_pixel = 8'd0;

    logic [7:0] di [2][8];
    logic       dv [2];
    logic [2:0] dcol [2];
    logic [7:0] dband [2];
    logic       ddone [2];

    always #5 clk = ~clk;

    parallel_window_feeder #(.IMG_W(W), .IMG_H(H), .ROW_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .I_00(di[0][0]), .I_01(di[0][1]), .I_02(di[0][2]), .I_03(di[0][3]),
        .I_10(di[0][4]), .I_11(di[0][5]), .I_12(di[0][6]), .I_13(di[0][7]),
        .out_valid(dv[0]), .out_col(dcol[0]), .out_band(dband[0]), .frame_done(ddone[0])
    );

    parallel_window_feeder #(.IMG_W(W), .IMG_H(H), .ROW_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .I_00(di[1][0]), .I_01(di[1][1]), .I_02(di[1][2]), .I_03(di[1][3]),
        .I_10(di[1][4]), .I_11(di[1][5]), .I_12(di[1][6]), .I_13(di[1][7]),
        .out_valid(dv[1]), .out_col(dcol[1]), .out_band(dband[1]), .frame_done(ddone[1])
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Image-level model: remembers every accepted pixel and cuts tiles straight out of the 2-D image.
    int         rs [2] = '{4, 1};
    logic [7:0] img [H][W];
    int         m_state = 0;   // 0 idle, 1 run, 2 done
    int         m_x = 0;
    int         m_y = 0;
    logic       ev [2];
    logic [7:0] ei [2][8];
    int         ecol [2];
    int         eband [2];
    logic       edone = 1'b0;

    int         cnt [2];
    logic       prev_v [2];
    logic [7:0] log4 [16][8];
    logic [7:0] log1 [40][8];

    task automatic chk(input string name, input int k, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d want=%0d at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic s, input logic [7:0] p);
        bit acc;
        if (r) begin
            m_state = 0; m_x = 0; m_y = 0; edone = 1'b0;
            for (int k = 0; k < 2; k++) begin
                ev[k] = 1'b0; ecol[k] = 0; eband[k] = 0;
                for (int j = 0; j < 8; j++) ei[k][j] = 8'd0;
            end
            return;
        end
        ev[0] = 1'b0; ev[1] = 1'b0; edone = 1'b0;
        acc = v && (s || m_state == 1);
        if (!acc) return;
        if (s) begin m_x = 0; m_y = 0; end
        img[m_y][m_x] = p;
        for (int k = 0; k < 2; k++) begin
            if (m_x % 2 == 1 && m_y >= 3 && (m_y - 3) % rs[k] == 0) begin
                ev[k] = 1'b1;
                ecol[k] = m_x / 2;
                eband[k] = (m_y - 3) / rs[k];
                for (int j = 0; j < 4; j++) begin
                    ei[k][j]     = img[m_y - 3 + j][m_x - 1];
                    ei[k][4 + j] = img[m_y - 3 + j][m_x];
                end
            end
        end
        if (m_x == W - 1 && m_y == H - 1) begin
            edone = 1'b1;
            m_state = 2;
        end else begin
            m_state = 1;
            if (m_x == W - 1) begin m_x = 0; m_y++; end
            else m_x++;
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic s, input logic [7:0] p);
        rst = r; in_valid = v; in_sof = s; in_pixel = p;
        @(posedge clk);
        model_step(r, v, s, p);
        #1;
    endtask

    // Drives ramp pixels p(x,y)=16y+x from index 'from' up to (not including) index 'upto'.
    task automatic ramp(input int from, input int upto, input bit sof_first, input bit gaps);
        for (int i = from; i < upto; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) cyc(1'b0, 1'b0, 1'b1, 8'hAA);
            cyc(1'b0, 1'b1, sof_first && i == from, 8'(i));
        end
    endtask

    task automatic clear_counts();
        cnt[0] = 0;
        cnt[1] = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("out_valid", k, int'(dv[k]), int'(ev[k]));
                chk("frame_done", k, int'(ddone[k]), int'(edone));
                chk("out_col", k, int'(dcol[k]), ecol[k]);
                chk("out_band", k, int'(dband[k]), eband[k]);
                for (int j = 0; j < 8; j++) chk("tile_pix", k * 10 + j, int'(di[k][j]), int'(ei[k][j]));
                if (dv[k] === 1'b1) begin
                    chk("back_to_back", k, int'(prev_v[k]), 0);
                    cnt[k]++;
                    for (int j = 0; j < 8; j++) begin
                        if (k == 0) log4[(int'(dband[0]) * 8 + int'(dcol[0])) % 16][j] = di[0][j];
                        else        log1[(int'(dband[1]) * 8 + int'(dcol[1])) % 40][j] = di[1][j];
                    end
                end
                prev_v[k] = dv[k];
            end
        end
    end

    logic [7:0] first4 [8] = '{8'd0, 8'd16, 8'd32, 8'd48, 8'd1, 8'd17, 8'd33, 8'd49};
    logic [7:0] last4  [8] = '{8'd78, 8'd94, 8'd110, 8'd126, 8'd79, 8'd95, 8'd111, 8'd127};

    initial begin
        prev_v[0] = 1'b0; prev_v[1] = 1'b0;
        clear_counts();
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        chk_en = 1'b1;

        // Pixels before any start of frame are dropped.
        clear_counts();
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 8'(i + 5));
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("idle_tiles", 0, cnt[0], 0);
        chk("idle_tiles", 1, cnt[1], 0);

        // Continuous ramp frame.
        clear_counts();
        ramp(0, W * H, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("tiles_cont", 0, cnt[0], 16);
        chk("tiles_cont", 1, cnt[1], 40);
        for (int j = 0; j < 8; j++) begin
            chk("first_tile", j, int'(log4[0][j]), int'(first4[j]));
            chk("last_tile", j, int'(log4[15][j]), int'(last4[j]));
        end
        chk("rs1_y4c2_I00", 0, int'(log1[10][0]), 20);
        chk("rs1_y4c2_I13", 0, int'(log1[10][7]), 69);

        // After frame end, pixels without a start of frame are dropped.
        clear_counts();
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 8'(200 + i));
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("done_tiles", 0, cnt[0], 0);
        chk("done_tiles", 1, cnt[1], 0);

        // Random valid gaps, with in_sof toggling on the idle cycles.
        clear_counts();
        ramp(0, W * H, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("tiles_gaps", 0, cnt[0], 16);
        chk("tiles_gaps", 1, cnt[1], 40);

        // Restart at (9,5): partial frame, then a full frame beginning with in_sof.
        ramp(0, 5 * W + 9, 1'b1, 1'b0);
        clear_counts();
        ramp(0, W * H, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("tiles_restart", 0, cnt[0], 16);
        chk("tiles_restart", 1, cnt[1], 40);

        // Reset on pixel (5,3), then pixels without in_sof.
        ramp(0, 3 * W + 5, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'(3 * W + 5));
        clear_counts();
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 8'(3 * W + 6 + i));
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        chk("after_rst_tiles", 0, cnt[0], 0);
        chk("after_rst_tiles", 1, cnt[1], 0);

        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parallel_window_feeder.md
# parallel_window_feeder

Upstream stage of `Parallel_filter`. It converts a raster-order 8-bit pixel stream into the 4-row by 2-column tiles that `Parallel_filter` consumes on its `I_00..I_13` inputs, one tile per column pair. Three line buffers hold the previous image rows. A column latch pairs even and odd columns. Row and column counters decide when a tile is complete and mark frame end.

## Interface
- `IMG_W`, default 256: pixels per row. Must be even and at least 4.
- `IMG_H`, default 256: rows per frame. Must be at least 4.
- `ROW_STEP`, default 4: vertical stride between emitted bands, in rows. Legal range 1..4.

Ports:
- `clk`, input, 1: single clock. All logic on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_pixel` is valid this cycle. There is no backpressure; the block accepts every valid pixel.
- `in_sof`, input, 1: start of frame. Qualified by `in_valid`; marks pixel (0,0).
- `in_pixel`, input, 8: pixel value.
- `I_00`..`I_03`, output, 8 each: column x-1, rows y-3..y.
- `I_10`..`I_13`, output, 8 each: column x, rows y-3..y.
- `out_valid`, output, 1: tile outputs valid. One-cycle pulse per tile.
- `out_col`, output, log2(IMG_W)-1 bits: column-pair index, (x-1)/2.
- `out_band`, output, 8: band index, (y-3)/ROW_STEP.
- `frame_done`, output, 1: one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Counters `x` (0..IMG_W-1) and `y` (0..IMG_H-1) track the position of the pixel being accepted.
- On an accepted pixel with `in_sof`=1: that pixel is (0,0), regardless of counter state.
- After (IMG_W-1, y): x goes to 0 and y increments.
- After (IMG_W-1, IMG_H-1): the block enters state DONE.
- States:
  - IDLE: waits for `in_sof`. Pixels without `in_sof` are dropped.
  - RUN: accepts pixels.
  - DONE: drops pixels until the next `in_sof`, which moves the block to RUN.
- Reset enters IDLE.
- Line buffers: three RAMs, LB0..LB2, each IMG_W x 8.
  - Pixel (x,y) is written to LB[y mod 3] at address x.
  - On the same cycle, all three buffers are read at address x.
  - Read-during-write to the same address returns the old data, i.e. row y-3.
  - Read results are mapped to rows y-3, y-2, y-1 by a rotation computed from y mod 3.
- Column latch:
  - On even x, store the four-value column (row y-3, row y-2, row y-1, `in_pixel`).
  - On odd x, the latched column drives `I_00..I_03` and the current column drives `I_10..I_13`.
- A tile is emitted on an accepted odd-x pixel when y >= 3 and (y-3) mod ROW_STEP = 0.
- Emitted tile data and `out_col`/`out_band` are held until the next tile.
- No tiles are emitted for y < 3. Rows beyond the last full band produce no tiles.
- `in_sof` mid-frame (RUN at any position): the frame restarts at (0,0).
  - Old line-buffer content is harmless because y < 3 gates emission.
  - A tile pending from the pre-restart pixel still completes normally.
- In IDLE, DONE, or on an `in_valid`=0 cycle: counters, latch and RAM writes do not change.

## Timing
- Reset values:
  - All `I_xx` = 0.
  - `out_valid` = 0, `out_col` = 0, `out_band` = 0, `frame_done` = 0.
  - Counters = 0, state = IDLE.
- RAM contents are not reset.
- Latency: the tile appears with `out_valid`=1 on the cycle after the odd-x pixel is accepted (one register stage). Synchronous RAM read is performed in the same cycle as the write.
- Maximum tile rate: one tile per two accepted pixels. `out_valid` is never high on consecutive cycles.
- `frame_done` pulses on the cycle after pixel (IMG_W-1, IMG_H-1) is accepted. It coincides with that pixel's tile `out_valid` when that tile exists.
- `rst` has priority over every input on the same edge. Reset mid-frame drops any pending tile: `out_valid`=0 on the following cycle.
- Gaps in `in_valid` are legal anywhere, including between the even and odd pixel of a pair. The latch holds across the gap.

## Test plan
- Ramp frame, IMG_W=16, IMG_H=8, ROW_STEP=4, p(x,y) = 16y+x, continuous `in_valid`:
  - Exactly 16 tiles are produced.
  - First tile (band 0, col 0): `I_00..I_03` = 0, 16, 32, 48; `I_10..I_13` = 1, 17, 33, 49.
  - Last tile (band 1, col 7): `I_00..I_03` = 78, 94, 110, 126; `I_10..I_13` = 79, 95, 111, 127.
  - `frame_done` asserts with the last tile.
- Same frame with ROW_STEP=1:
  - 40 tiles, for rows 3..7.
  - Tile for y=4, col 2: `I_00` = 20, `I_13` = 69.
- Random `in_valid` gaps (about 50% duty) on the ramp frame:
  - The tile sequence is identical to the continuous case.
  - `out_valid` is never asserted on back-to-back cycles.
- Pixels before the first `in_sof` and after frame end:
  - No tiles are produced and no counter moves.
  - The next `in_sof` frame reproduces the first scenario exactly.
- `in_sof` at (9,5) mid-frame, then a full ramp frame:
  - Output matches the first scenario from restart on.
  - No tile is produced for y < 3 of the new frame.
- `rst` asserted at pixel (5,3) for 1 cycle:
  - All outputs read 0 on the next cycle.
  - Following pixels without `in_sof` are dropped.
